// File: rtl/change_dispenser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : change_dispenser
// Description : Pays out a change amount greedily from four per-denomination
//               coin inventories, one coin per strobe, on the shared coin bus
//               encoding (00=1, 01=2, 10=5, 11=10 units). Reports completion
//               and whether exact change was impossible.
// Ports       : clk, reset (async, active-low)
//               change_valid/change_amount/change_ready : request handshake
//               load_coin/load_code/load_count          : inventory refill
//               coin_out/coin_pulse                     : coin eject bus
//               done/short/remaining                    : completion status
// Revision    : 1.0 - initial release
// ============================================================================
module change_dispenser #(
    parameter int CNT_W        = 6,
    parameter int PULSE_CYCLES = 5,
    parameter int GAP_CYCLES   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             change_valid,
    input  logic [8:0]       change_amount,
    output logic             change_ready,
    input  logic             load_coin,
    input  logic [1:0]       load_code,
    input  logic [CNT_W-1:0] load_count,
    output logic [1:0]       coin_out,
    output logic             coin_pulse,
    output logic             done,
    output logic             short,
    output logic [8:0]       remaining
);

    localparam int             TMR_W      = 8;
    localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t           state_q,     state_d;
    logic [8:0]       remaining_q, remaining_d;
    logic             short_q,     short_d;
    logic [1:0]       coin_q,      coin_d;
    logic [TMR_W-1:0] tmr_q,       tmr_d;
    logic [CNT_W-1:0] inv_q [4];
    logic [CNT_W-1:0] inv_d [4];

    function automatic logic [8:0] coin_value(input logic [1:0] code);
        case (code)
            2'b00:   coin_value = 9'd1;
            2'b01:   coin_value = 9'd2;
            2'b10:   coin_value = 9'd5;
            default: coin_value = 9'd10;
        endcase
    endfunction

    // Greedy pick: values rise with the code, so scanning codes downward and
    // keeping the first hit yields the largest affordable, in-stock coin.
    logic       sel_found;
    logic [1:0] sel_code;
    logic [8:0] sel_value;

    always_comb begin
        sel_found = 1'b0;
        sel_code  = 2'b00;
        sel_value = 9'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!sel_found && (inv_q[i] != '0) &&
                (coin_value(2'(i)) <= remaining_q)) begin
                sel_found = 1'b1;
                sel_code  = 2'(i);
                sel_value = coin_value(2'(i));
            end
        end
    end

    // Saturating refill: the extra carry bit flags overflow, which clamps.
    logic [CNT_W:0]   load_sum;
    logic [CNT_W-1:0] load_sat;

    always_comb begin
        load_sum = {1'b0, inv_q[load_code]} + {1'b0, load_count};
        load_sat = load_sum[CNT_W] ? {CNT_W{1'b1}} : load_sum[CNT_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        short_d     = short_q;
        coin_d      = coin_q;
        tmr_d       = tmr_q;
        for (int i = 0; i < 4; i++) begin
            inv_d[i] = inv_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (load_coin) begin
                    inv_d[load_code] = load_sat;
                end
                if (change_valid) begin
                    remaining_d = change_amount;
                    short_d     = 1'b0;
                    state_d     = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (remaining_q == 9'd0) begin
                    short_d = 1'b0;
                    state_d = ST_DONE;
                end else if (sel_found) begin
                    coin_d           = sel_code;
                    remaining_d      = remaining_q - sel_value;
                    inv_d[sel_code]  = inv_q[sel_code] - CNT_W'(1);
                    tmr_d            = '0;
                    state_d          = ST_PULSE;
                end else begin
                    short_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_PULSE: begin
                if (tmr_q == PULSE_LAST) begin
                    tmr_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_GAP: begin
                if (tmr_q == GAP_LAST) begin
                    tmr_d   = '0;
                    state_d = ST_SELECT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= 9'd0;
            short_q     <= 1'b0;
            coin_q      <= 2'b00;
            tmr_q       <= '0;
            for (int i = 0; i < 4; i++) begin
                inv_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            short_q     <= short_d;
            coin_q      <= coin_d;
            tmr_q       <= tmr_d;
            for (int i = 0; i < 4; i++) begin
                inv_q[i] <= inv_d[i];
            end
        end
    end

    // Status strobes decode straight from the state register so that an
    // asynchronous reset drops coin_pulse without waiting for a clock.
    assign change_ready = (state_q == ST_IDLE);
    assign coin_pulse   = (state_q == ST_PULSE);
    assign done         = (state_q == ST_DONE);
    assign coin_out     = coin_q;
    assign short        = short_q;
    assign remaining    = remaining_q;

endmodule
`default_nettype wire
